// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//
// Round-robin write-side arbiter sharing one event FIFO write port between
// NUM_REQ producers with valid/ready handshakes. At most one producer is
// granted per cycle; the granted word is registered onto the FIFO write port
// one cycle later. The FIFO's full/full_next flags gate every grant so that
// no write is ever issued that the FIFO would drop.
//
// Optional feature macro: FIFO_ARB_SRC_TAG_EN
//   defined   -> fifo_write_data = {source index, payload}
//   undefined -> fifo_write_data = payload only
//
// Reset is synchronous, active-high.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  localparam int SRC_W     = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
`ifdef FIFO_ARB_SRC_TAG_EN
  localparam int FIFO_WIDTH = DATA_WIDTH + SRC_W
`else
  localparam int FIFO_WIDTH = DATA_WIDTH
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_write_en,
  output logic [FIFO_WIDTH-1:0]         fifo_write_data,
  input  logic                          fifo_full,
  input  logic                          fifo_full_next,
  output logic [SRC_W-1:0]              grant_idx,
  output logic [CNT_WIDTH-1:0]          stall_count
);

  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_REQ - 1);
  localparam logic [SRC_W:0]   NUM_EXT  = (SRC_W+1)'(NUM_REQ);

  // Registered state and its next-state values
  logic                  wr_en_q,   wr_en_d;
  logic [FIFO_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [SRC_W-1:0]      gidx_q,    gidx_d;
  logic [SRC_W-1:0]      ptr_q,     ptr_d;
  logic [CNT_WIDTH-1:0]  stall_q,   stall_d;

  // Arbitration intermediates
  logic                  can_write;
  logic                  found;
  logic [SRC_W-1:0]      sel_idx;
  logic [SRC_W:0]        cand;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  accept;
  logic [FIFO_WIDTH-1:0] sel_word;

  // Conservative space check: a write registered now lands at this edge, so
  // full_next decides whether another one may follow. Reads are not credited.
  assign can_write = !fifo_full && !(wr_en_q && fifo_full_next);

  // Round-robin search: first valid producer at or after the priority pointer
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (SRC_W+1)'(k);
      if (cand >= NUM_EXT) begin
        cand = cand - NUM_EXT;
      end
      if (!found && req_valid[cand[SRC_W-1:0]]) begin
        found   = 1'b1;
        sel_idx = cand[SRC_W-1:0];
      end
    end
  end

  // A grant is only real when there is space and reset is not asserted;
  // a word handed over during reset is discarded.
  assign accept   = found && can_write && !rst;
  assign sel_data = req_data[sel_idx*DATA_WIDTH +: DATA_WIDTH];

`ifdef FIFO_ARB_SRC_TAG_EN
  assign sel_word = {sel_idx, sel_data};
`else
  assign sel_word = sel_data;
`endif

  // One-hot ready toward the producers, combinational from the request side
  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[sel_idx] = 1'b1;
    end
  end

  // Next-state logic: write strobe, word, source index, pointer, stall count
  always_comb begin
    wr_en_d   = accept;
    wr_data_d = wr_data_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    stall_d   = stall_q;
    if (accept) begin
      wr_data_d = sel_word;
      gidx_d    = sel_idx;
      ptr_d     = (sel_idx == LAST_IDX) ? '0 : sel_idx + SRC_W'(1);
    end
    // Blocked cycles saturate instead of wrapping
    if ((|req_valid) && !can_write && (stall_q != {CNT_WIDTH{1'b1}})) begin
      stall_d = stall_q + CNT_WIDTH'(1);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      gidx_q    <= '0;
      ptr_q     <= '0;
      stall_q   <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      gidx_q    <= gidx_d;
      ptr_q     <= ptr_d;
      stall_q   <= stall_d;
    end
  end

  assign fifo_write_en   = wr_en_q;
  assign fifo_write_data = wr_data_q;
  assign grant_idx       = gidx_q;
  assign stall_count     = stall_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Testbench for fifo_write_arbiter: directed scenarios with literal
// expectations plus a randomized run against a behavioural model.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int SW = 2;
`ifdef FIFO_ARB_SRC_TAG_EN
  localparam int FW  = DW + SW;
  localparam bit TAG = 1'b1;
`else
  localparam int FW  = DW;
  localparam bit TAG = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_write_en;
  logic [FW-1:0]   fifo_write_data;
  logic            fifo_full;
  logic            fifo_full_next;
  logic [SW-1:0]   grant_idx;
  logic [CW-1:0]   stall_count;

  fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .fifo_write_en(fifo_write_en),
    .fifo_write_data(fifo_write_data),
    .fifo_full(fifo_full),
    .fifo_full_next(fifo_full_next),
    .grant_idx(grant_idx),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int m_ptr, m_wen, m_wdata, m_gidx, m_stall, m_grant;
  bit m_space;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // First valid producer scanning upward from the pointer, wrapping around
  function automatic int pick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Mid-cycle comparison of every output against the model
  task automatic cyc_check();
    int exp_ready;
    #4;
    m_space   = !fifo_full && !((m_wen != 0) && fifo_full_next);
    m_grant   = (!rst && m_space) ? pick(m_ptr, req_valid) : -1;
    exp_ready = (m_grant >= 0) ? (1 << m_grant) : 0;
    chk("ready", req_ready, exp_ready);
    chk("wen", fifo_write_en, m_wen);
    chk("wdata", fifo_write_data, m_wdata);
    chk("gidx", grant_idx, m_gidx);
    chk("stall", stall_count, m_stall);
  endtask

  // Model update for the coming edge, then advance to just after it
  task automatic cyc_adv();
    int d;
    if (rst) begin
      m_wen = 0; m_wdata = 0; m_gidx = 0; m_ptr = 0; m_stall = 0;
    end else begin
      if ((req_valid != 0) && !m_space && (m_stall < (1 << CW) - 1)) m_stall++;
      if (m_grant >= 0) begin
        d       = int'((req_data >> (m_grant * DW)) & {{(N*DW-DW){1'b0}}, {DW{1'b1}}});
        m_wen   = 1;
        m_wdata = TAG ? ((m_grant << DW) | d) : d;
        m_gidx  = m_grant;
        m_ptr   = (m_grant + 1) % N;
      end else begin
        m_wen = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; fifo_full = 1'b0; fifo_full_next = 1'b0;
    cyc_check();
    cyc_adv();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0;
    fifo_full = 1'b0; fifo_full_next = 1'b0;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
    @(posedge clk);
    #1;
    m_ptr = 0; m_wen = 0; m_wdata = 0; m_gidx = 0; m_stall = 0; m_grant = -1;

    // Reset held two cycles with all producers requesting
    req_valid = 4'b1111;
    repeat (2) begin
      cyc_check();
      chk("rst_ready", req_ready, 0);
      chk("rst_wen", fifo_write_en, 0);
      chk("rst_stall", stall_count, 0);
      cyc_adv();
    end
    rst = 1'b0;
    cyc_check();
    chk("first_grant", req_ready, 4'b0001);
    cyc_adv();

    // Single producer
    do_reset();
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 8'hA5;
    cyc_check();
    chk("single_ready", req_ready, 4'b0100);
    cyc_adv();
    req_valid = '0;
    cyc_check();
    chk("single_wen", fifo_write_en, 1);
    chk("single_wdata", fifo_write_data, TAG ? 'h2A5 : 'hA5);
    chk("single_gidx", grant_idx, 2);
    cyc_adv();

    // Fairness under full contention
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      cyc_check();
      chk("fair_ready", req_ready, 1 << (k % 4));
      if (k > 0) chk("fair_wen", fifo_write_en, 1);
      cyc_adv();
    end
    req_valid = '0;
    cyc_check();
    chk("fair_wen_last", fifo_write_en, 1);
    chk("fair_gidx_last", grant_idx, 3);
    cyc_adv();

    // FIFO full for five cycles
    do_reset();
    req_valid = 4'b0010;
    fifo_full = 1'b1;
    repeat (5) begin
      cyc_check();
      chk("full_ready", req_ready, 0);
      cyc_adv();
    end
    fifo_full = 1'b0;
    cyc_check();
    chk("full_stall", stall_count, 5);
    chk("full_release", req_ready, 4'b0010);
    cyc_adv();
    req_valid = '0;
    cyc_check();
    chk("full_gidx", grant_idx, 1);
    cyc_adv();

    // Pending write plus full_next blocks the next grant
    do_reset();
    req_valid = 4'b1000;
    fifo_full_next = 1'b1;
    cyc_check();
    chk("fn_first", req_ready, 4'b1000);
    cyc_adv();
    cyc_check();
    chk("fn_block", req_ready, 0);
    chk("fn_wen", fifo_write_en, 1);
    cyc_adv();
    cyc_check();
    chk("fn_stall", stall_count, 1);
    chk("fn_regrant", req_ready, 4'b1000);
    cyc_adv();
    req_valid = '0; fifo_full_next = 1'b0;

    // Stall counter saturation
    do_reset();
    req_valid = 4'b0001;
    fifo_full = 1'b1;
    repeat (20) begin
      cyc_check();
      cyc_adv();
    end
    cyc_check();
    chk("sat_stall", stall_count, 15);
    cyc_adv();
    fifo_full = 1'b0; req_valid = '0;

    // Reset in the cycle the write for producer 2 is presented
    do_reset();
    req_valid = 4'b0100;
    cyc_check();
    chk("mid_grant", req_ready, 4'b0100);
    cyc_adv();
    req_valid = 4'b1111;
    rst = 1'b1;
    cyc_check();
    chk("mid_wen_pre", fifo_write_en, 1);
    chk("mid_ready_rst", req_ready, 0);
    cyc_adv();
    rst = 1'b0;
    cyc_check();
    chk("mid_wen", fifo_write_en, 0);
    chk("mid_gidx", grant_idx, 0);
    chk("mid_ptr0", req_ready, 4'b0001);
    cyc_adv();

    // Randomized run: producers hold word until accepted
    req_valid = '0;
    m_grant = -1;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_grant == i) begin
          req_valid[i] = ($urandom % 2) == 0;
          req_data[i*DW +: DW] = DW'($urandom);
        end else if (!req_valid[i]) begin
          req_valid[i] = ($urandom % 3) == 0;
          req_data[i*DW +: DW] = DW'($urandom);
        end
      end
      fifo_full      = ($urandom % 4) == 0;
      fifo_full_next = ($urandom % 3) == 0;
      rst            = ($urandom % 60) == 0;
      cyc_check();
      cyc_adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
